// File: rtl/cbfp0_min_gen.sv
// CBFP0 minimum-exponent producer: per-group minimum leading-sign count of a
// complex sample stream, queued in a small FIFO and popped by the shift stage.
module cbfp0_min_gen #(
  parameter int DW     = 13,
  parameter int LANES  = 4,
  parameter int BEATS  = 4,
  parameter int GROUPS = 8,
  parameter int DEPTH  = 8,
  parameter int LZW    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  din_valid,
  input  logic [LANES*DW-1:0]   din_re,
  input  logic [LANES*DW-1:0]   din_im,
  input  logic                  min_fin_en,
  output logic                  min_4s_en,
  output logic [LZW-1:0]        min_exp,
  output logic                  min_valid,
  output logic                  fifo_full,
  output logic                  ovf_err,
  output logic                  unf_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [LZW-1:0] LSC_MAX = LZW'(DW - 1);

  // Redundant sign bits below the MSB; a value of all sign bits saturates at DW-1.
  function automatic logic [LZW-1:0] lsc(input logic [DW-1:0] v);
    logic [LZW-1:0] n;
    logic           run;
    n   = '0;
    run = 1'b1;
    for (int i = DW - 2; i >= 0; i--) begin
      if (run && (v[i] == v[DW-1])) n = n + LZW'(1);
      else                          run = 1'b0;
    end
    return n;
  endfunction

  logic [BW-1:0]  beat_cnt;
  logic [GW-1:0]  grp_cnt;
  logic [LZW-1:0] running_min;
  logic [LZW-1:0] beat_min;
  logic [LZW-1:0] grp_min;
  logic [LZW-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           last_beat;
  logic           pop_ok;
  logic           push_ok;

  always_comb begin
    beat_min = LSC_MAX;
    for (int l = 0; l < LANES; l++) begin
      if (lsc(din_re[l*DW +: DW]) < beat_min) beat_min = lsc(din_re[l*DW +: DW]);
      if (lsc(din_im[l*DW +: DW]) < beat_min) beat_min = lsc(din_im[l*DW +: DW]);
    end
  end

  // A pop frees its slot first, so a simultaneous push into a full FIFO still lands;
  // an empty FIFO never bypasses the incoming entry to the reader.
  assign grp_min   = (beat_min < running_min) ? beat_min : running_min;
  assign last_beat = din_valid && (beat_cnt == BW'(BEATS - 1));
  assign pop_ok    = min_fin_en && (count != '0);
  assign push_ok   = last_beat && ((count != (AW+1)'(DEPTH)) || pop_ok);
  assign fifo_full = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= grp_min;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt    <= '0;
      grp_cnt     <= '0;
      running_min <= LSC_MAX;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      min_4s_en   <= 1'b0;
      min_exp     <= '0;
      min_valid   <= 1'b0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
    end else begin
      if (din_valid) begin
        if (last_beat) begin
          beat_cnt    <= '0;
          running_min <= LSC_MAX;
          grp_cnt     <= (grp_cnt == GW'(GROUPS - 1)) ? '0 : grp_cnt + GW'(1);
        end else begin
          beat_cnt    <= beat_cnt + BW'(1);
          running_min <= grp_min;
        end
      end

      min_4s_en <= last_beat && (grp_cnt == '0);

      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        min_exp <= mem[rd_ptr];
      end
      min_valid <= pop_ok;

      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (last_beat && !push_ok)  ovf_err <= 1'b1;
      if (min_fin_en && !pop_ok)  unf_err <= 1'b1;
    end
  end

endmodule
